// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared mode codes, write-FSM states and default timing for the DAC controller
package dac_pkg;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_NEXT,
        ST_LOAD
    } wr_state_t;

    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_WR_CYC    = 4;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_TICK_DIV  = 50000;

endpackage

// File: rtl/dac_bus_writer.sv
// rtl/dac_bus_writer.sv - snapshots all channel values and writes them to a parallel DAC bus
module dac_bus_writer
    import dac_pkg::*;
#(
    parameter int DW        = 8,
    parameter int NCH       = 2,
    parameter int CH_W      = 1,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WR_CYC    = DEF_WR_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NCH*DW-1:0] snap_in,
    output logic              csn,
    output logic              wrn,
    output logic              ldacn,
    output logic [CH_W-1:0]   addr,
    output logic [DW-1:0]     d,
    output logic              busy,
    output logic              done
);

    localparam int CMAX_SW = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
    localparam int CMAX    = (CMAX_SW > HOLD_CYC) ? CMAX_SW : HOLD_CYC;
    localparam int CNT_W   = $clog2(CMAX + 1);

    wr_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    ch_nx;
    logic [DW-1:0]      snap [NCH];

    assign ch_nx = ch + CH_W'(1);

    // Frame sequencer: each channel gets setup/strobe/hold/gap, then one ldacn pulse latches all
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ch    <= '0;
            for (int i = 0; i < NCH; i++) snap[i] <= '0;
            csn   <= 1'b1;
            wrn   <= 1'b1;
            ldacn <= 1'b1;
            addr  <= '0;
            d     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SETUP;
                        for (int i = 0; i < NCH; i++) snap[i] <= snap_in[i*DW +: DW];
                        ch    <= '0;
                        cnt   <= '0;
                        csn   <= 1'b0;
                        addr  <= '0;
                        d     <= snap_in[DW-1:0];
                        busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                        state <= ST_WRITE;
                        cnt   <= '0;
                        wrn   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (cnt == CNT_W'(WR_CYC - 1)) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        wrn   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                        state <= ST_NEXT;
                        cnt   <= '0;
                        csn   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (ch == CH_W'(NCH - 1)) begin
                        state <= ST_LOAD;
                        ldacn <= 1'b0;
                    end else begin
                        state <= ST_SETUP;
                        ch    <= ch_nx;
                        csn   <= 1'b0;
                        addr  <= ch_nx;
                        d     <= snap[ch_nx];
                    end
                end
                ST_LOAD: begin
                    if (cnt == CNT_W'(WR_CYC - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        ldacn <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dac_multich_ctrl.sv
// rtl/dac_multich_ctrl.sv - multi-channel DAC value/waveform controller with timed bus writes
module dac_multich_ctrl
    import dac_pkg::*;
#(
    parameter int DW        = 8,
    parameter int NCH       = 2,
    parameter int CH_W      = 1,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WR_CYC    = DEF_WR_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int TICK_DIV  = DEF_TICK_DIV
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_zero,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [1:0]        mode_in,
    input  logic              mode_set,
    input  logic [DW-1:0]     step,
    output logic              dac_csn,
    output logic              dac_wrn,
    output logic              dac_ldacn,
    output logic [CH_W-1:0]   dac_addr,
    output logic [DW-1:0]     dac_d,
    output logic              busy,
    output logic [NCH*DW-1:0] ch_val,
    output logic [DW-1:0]     led_out
);

    localparam int TW = $clog2(TICK_DIV);

    logic [DW-1:0]  vals    [NCH];
    logic [DW-1:0]  vals_nx [NCH];
    logic [1:0]     modes   [NCH];
    logic [NCH-1:0] dir_up;
    logic [NCH-1:0] dir_nx;
    logic [NCH-1:0] dirty;
    logic [TW-1:0]  div_cnt;
    logic           tick;
    logic           snap_take;
    logic           unused_done;

    // Carry out of an unsigned DW-bit add
    function automatic logic add_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW];
    endfunction

    assign tick      = (div_cnt == TW'(TICK_DIV - 1));
    assign snap_take = (|dirty) & ~busy;

    // Free-running waveform tick divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_cnt <= '0;
        else      div_cnt <= tick ? '0 : div_cnt + TW'(1);
    end

    // Next value and direction per channel; buttons are judged under the current mode
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            vals_nx[i] = vals[i];
            dir_nx[i]  = dir_up[i];
            if (btn_zero && (ch_sel == CH_W'(i))) begin
                vals_nx[i] = '0;
                dir_nx[i]  = 1'b1;
            end else begin
                case (modes[i])
                    MODE_SAW: begin
                        if (tick) vals_nx[i] = vals[i] + step;
                    end
                    MODE_TRI: begin
                        if (tick) begin
                            if (dir_up[i]) begin
                                if (add_ovf(vals[i], step)) begin
                                    vals_nx[i] = '1;
                                    dir_nx[i]  = 1'b0;
                                end else begin
                                    vals_nx[i] = vals[i] + step;
                                end
                            end else begin
                                if (vals[i] < step) begin
                                    vals_nx[i] = '0;
                                    dir_nx[i]  = 1'b1;
                                end else begin
                                    vals_nx[i] = vals[i] - step;
                                end
                            end
                        end
                    end
                    default: begin
                        if (btn_up && (ch_sel == CH_W'(i))) begin
                            vals_nx[i] = add_ovf(vals[i], step) ? '1 : vals[i] + step;
                        end else if (btn_dn && (ch_sel == CH_W'(i))) begin
                            vals_nx[i] = (vals[i] < step) ? '0 : vals[i] - step;
                        end
                    end
                endcase
            end
        end
    end

    // Channel registers, mode loads and dirty flags (a fresh change beats the snapshot clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                vals[i]  <= '0;
                modes[i] <= MODE_STATIC;
            end
            dir_up <= '1;
            dirty  <= '1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                vals[i] <= vals_nx[i];
                if (mode_set && (ch_sel == CH_W'(i))) begin
                    modes[i]  <= mode_in;
                    dir_up[i] <= 1'b1;
                end else begin
                    dir_up[i] <= dir_nx[i];
                end
                dirty[i] <= (vals_nx[i] != vals[i]) | (dirty[i] & ~snap_take);
            end
        end
    end

    // Flattened channel view and selected-channel LED value
    always_comb begin
        ch_val  = '0;
        led_out = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_val[i*DW +: DW] = vals[i];
            if (ch_sel == CH_W'(i)) led_out = vals[i];
        end
    end

    dac_bus_writer #(
        .DW        (DW),
        .NCH       (NCH),
        .CH_W      (CH_W),
        .SETUP_CYC (SETUP_CYC),
        .WR_CYC    (WR_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_writer (
        .clk     (clk),
        .rst     (rst),
        .start   (|dirty),
        .snap_in (ch_val),
        .csn     (dac_csn),
        .wrn     (dac_wrn),
        .ldacn   (dac_ldacn),
        .addr    (dac_addr),
        .d       (dac_d),
        .busy    (busy),
        .done    (unused_done)
    );

endmodule
